// File: rtl/alu_op_issuer.sv
// alu_op_issuer: decodes ALUOp/funct into ALU_control/bonus_control and issues the
// result through a registered output stage backed by a one-entry skid buffer.
module alu_op_issuer #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALU_control,
    output logic [2:0]       bonus_control,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Decoded operation plus its tag; one of these lives in each storage slot.
    typedef struct packed {
        logic [3:0]       ctrl;
        logic [2:0]       bonus;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    entry_t           dec;
    entry_t           out_q, out_d;
    entry_t           skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, xfer;

    // Decode the offered operation; unknown encodings fall back to ADD and flag illegal.
    always_comb begin
        dec.ctrl    = 4'd2;
        dec.bonus   = 3'b000;
        dec.tag     = in_tag;
        dec.illegal = 1'b0;
        unique case (in_aluop)
            3'b000: dec.ctrl = 4'd2;
            3'b001: dec.ctrl = 4'd6;
            3'b011: dec.ctrl = 4'd7;
            3'b100: dec.ctrl = 4'd1;
            3'b101: dec.ctrl = 4'd0;
            3'b010: begin
                unique case (in_funct)
                    6'h20: dec.ctrl = 4'd2;
                    6'h22: dec.ctrl = 4'd6;
                    6'h24: dec.ctrl = 4'd0;
                    6'h25: dec.ctrl = 4'd1;
                    6'h18: dec.ctrl = 4'd8;
                    6'h2A: begin dec.ctrl = 4'd7; dec.bonus = 3'b000; end
                    6'h2B: begin dec.ctrl = 4'd7; dec.bonus = 3'b001; end
                    6'h2C: begin dec.ctrl = 4'd7; dec.bonus = 3'b010; end
                    6'h2D: begin dec.ctrl = 4'd7; dec.bonus = 3'b011; end
                    6'h2E: begin dec.ctrl = 4'd7; dec.bonus = 3'b110; end
                    6'h2F: begin dec.ctrl = 4'd7; dec.bonus = 3'b100; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    // Next-state for output register, skid register and illegal counter.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (skid_valid_q) begin
            // in_ready is low here, so only draining is possible.
            if (xfer) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || xfer) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end

        if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards both stored entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign ALU_control   = out_q.ctrl;
    assign bonus_control = out_q.bonus;
    assign out_tag       = out_q.tag;
    assign out_illegal   = out_q.illegal;
    assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed, table-driven bench for alu_op_issuer.
module tb_alu_op_issuer;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_aluop;
    logic [5:0]       in_funct;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       ALU_control;
    logic [2:0]       bonus_control;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int checks;
    int errors;
    int exp_cnt;

    alu_op_issuer #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_aluop     (in_aluop),
        .in_funct     (in_funct),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ALU_control  (ALU_control),
        .bonus_control(bonus_control),
        .out_tag      (out_tag),
        .out_illegal  (out_illegal),
        .illegal_cnt  (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] aluop;
        logic [5:0] funct;
        logic [4:0] tag;
        logic [3:0] ctrl;
        logic [2:0] bonus;
        logic       ill;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] a, input logic [5:0] f, input logic [4:0] t);
        in_valid = 1'b1;
        in_aluop = a;
        in_funct = f;
        in_tag   = t;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;

        vecs[0]  = '{3'b000, 6'h22, 5'd1,  4'd2, 3'b000, 1'b0};
        vecs[1]  = '{3'b001, 6'h20, 5'd2,  4'd6, 3'b000, 1'b0};
        vecs[2]  = '{3'b011, 6'h22, 5'd3,  4'd7, 3'b000, 1'b0};
        vecs[3]  = '{3'b100, 6'h24, 5'd4,  4'd1, 3'b000, 1'b0};
        vecs[4]  = '{3'b101, 6'h25, 5'd5,  4'd0, 3'b000, 1'b0};
        vecs[5]  = '{3'b010, 6'h22, 5'd7,  4'd6, 3'b000, 1'b0};
        vecs[6]  = '{3'b010, 6'h20, 5'd8,  4'd2, 3'b000, 1'b0};
        vecs[7]  = '{3'b010, 6'h24, 5'd9,  4'd0, 3'b000, 1'b0};
        vecs[8]  = '{3'b010, 6'h25, 5'd10, 4'd1, 3'b000, 1'b0};
        vecs[9]  = '{3'b010, 6'h18, 5'd11, 4'd8, 3'b000, 1'b0};
        vecs[10] = '{3'b010, 6'h2A, 5'd12, 4'd7, 3'b000, 1'b0};
        vecs[11] = '{3'b010, 6'h2B, 5'd13, 4'd7, 3'b001, 1'b0};
        vecs[12] = '{3'b010, 6'h2C, 5'd14, 4'd7, 3'b010, 1'b0};
        vecs[13] = '{3'b010, 6'h2D, 5'd15, 4'd7, 3'b011, 1'b0};
        vecs[14] = '{3'b010, 6'h2E, 5'd16, 4'd7, 3'b110, 1'b0};
        vecs[15] = '{3'b010, 6'h2F, 5'd17, 4'd7, 3'b100, 1'b0};
        vecs[16] = '{3'b010, 6'h3F, 5'd18, 4'd2, 3'b000, 1'b1};
        vecs[17] = '{3'b111, 6'h2A, 5'd19, 4'd2, 3'b000, 1'b1};

        // Reset held with in_valid high.
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(3'b001, 6'h00, 5'd31);
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({ALU_control, bonus_control, out_tag, out_illegal}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;

        // Decode sweep at full throughput; first vector lands on the first edge after release.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].aluop, vecs[i].funct, vecs[i].tag);
            step();
            if (vecs[i].ill) exp_cnt++;
            chk($sformatf("vec%0d_out", i),
                32'({out_valid, ALU_control, bonus_control, out_tag, out_illegal}),
                32'({1'b1, vecs[i].ctrl, vecs[i].bonus, vecs[i].tag, vecs[i].ill}));
            chk($sformatf("vec%0d_cnt", i), 32'(illegal_cnt), 32'(exp_cnt));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        chk("illegal_cnt_two", 32'(illegal_cnt), 32'd2);
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Stall: tags 1,2,3 with out_ready low.
        out_ready = 1'b0;
        drive(3'b000, 6'h00, 5'd1);
        step();
        chk("stall1_tag", 32'(out_tag), 32'd1);
        chk("stall1_in_ready", 32'(in_ready), 32'd1);
        drive(3'b001, 6'h00, 5'd2);
        step();
        chk("stall2_tag", 32'(out_tag), 32'd1);
        chk("stall2_in_ready", 32'(in_ready), 32'd0);
        drive(3'b100, 6'h00, 5'd3);
        step();
        chk("stall3_hold", 32'({out_valid, out_tag, ALU_control}), 32'({1'b1, 5'd1, 4'd2}));
        chk("stall3_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("drain_tag2", 32'({out_valid, out_tag, ALU_control}), 32'({1'b1, 5'd2, 4'd6}));
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("drain_tag3", 32'({out_valid, out_tag, ALU_control}), 32'({1'b1, 5'd3, 4'd1}));
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Saturation: 300 illegal operations at full rate.
        for (int i = 0; i < 300; i++) begin
            drive(3'b110, 6'h00, 5'(i));
            step();
            if (exp_cnt < 255) exp_cnt++;
            chk($sformatf("sat%0d_cnt", i), 32'(illegal_cnt), 32'(exp_cnt));
        end
        chk("sat_final", 32'(illegal_cnt), 32'd255);
        drive(3'b010, 6'h01, 5'd0);
        step();
        chk("sat_hold", 32'(illegal_cnt), 32'd255);

        // Mid-flight reset with output and skid full.
        out_ready = 1'b0;
        drive(3'b000, 6'h00, 5'd4);
        step();
        drive(3'b000, 6'h00, 5'd5);
        step();
        chk("mid_full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cnt", 32'(illegal_cnt), 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(3'b001, 6'h00, 5'd9);
        step();
        in_valid = 1'b0;
        chk("post_rst_first", 32'({out_valid, out_tag, ALU_control}), 32'({1'b1, 5'd9, 4'd6}));
        step();
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Decode-and-issue stage that produces the `ALU_control` / `bonus_control` encoding consumed by the datapath ALU. It accepts the main-control `ALUOp` and instruction `funct` field over a valid/ready handshake and decodes them into ALU operation codes. It presents the result, with a destination tag, through a registered output stage backed by a one-entry skid buffer. It sits between instruction decode and the EX-stage ALU, and sustains one operation per cycle under continuous flow.

## Interface
Parameters:
- `TAG_W`, 5: width of the pass-through destination tag (register number).
- `CNT_W`, 8: width of the saturating illegal-operation counter.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: upstream offers an operation.
- `in_ready` output 1: block can accept this cycle.
- `in_aluop` input 3: main-control ALUOp.
- `in_funct` input 6: instruction funct field.
- `in_tag` input TAG_W: destination tag, passed through unchanged.
- `out_valid` output 1: decoded operation present.
- `out_ready` input 1: ALU stage consumes this cycle.
- `ALU_control` output 4: ALU operation code.
- `bonus_control` output 3: comparison selector, meaningful when `ALU_control`=7.
- `out_tag` output TAG_W: tag of the presented operation.
- `out_illegal` output 1: presented operation was undecodable.
- `illegal_cnt` output CNT_W: saturating count of accepted illegal operations.

## Operation
Decode applies to `in_*` at acceptance. Unlisted `bonus_control` is 000.
- ALUOp 000 -> ADD (2); 001 -> SUB (6); 011 -> compare (7/000, slti); 100 -> OR (1); 101 -> AND (0).
- ALUOp 010 (R-type), by funct:
  - 0x20 -> 2; 0x22 -> 6; 0x24 -> 0; 0x25 -> 1; 0x18 -> MUL (8).
  - 0x2A -> 7/000 (slt); 0x2B -> 7/001 (sgt); 0x2C -> 7/010 (sle); 0x2D -> 7/011 (sge); 0x2E -> 7/110 (seq); 0x2F -> 7/100 (sne).
- Any other ALUOp, or an unlisted funct under 010 -> `ALU_control`=2, `bonus_control`=000, `out_illegal`=1.

Storage is an output register (`out_*`) plus one skid register (decoded fields, tag, illegal bit).
- Accept when `in_valid && in_ready`; transfer out when `out_valid && out_ready`.
- `in_ready` = skid register empty; it is a registered signal, never combinational from `out_ready`.
- Accept while the output register is empty, or draining this cycle -> decoded entry loads the output register.
- Accept while the output register is held (`out_valid && !out_ready`) -> entry loads the skid register; `in_ready` drops next cycle.
- Output transfers while skid is full -> skid moves to the output register; `in_ready` rises next cycle.
- Simultaneous accept and transfer with skid empty -> new entry replaces the output; `out_valid` stays 1.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- While `out_valid`=1 and `out_ready`=0, all `out_*` signals are held stable.

Illegal counter:
- Increments by 1 on each accepted illegal operation.
- Counts at acceptance, not at output.
- Saturates at 2^CNT_W-1 (255); never wraps.

## Timing
- Reset (async assert): `out_valid`=0, `ALU_control`=0, `bonus_control`=0, `out_tag`=0, `out_illegal`=0, `illegal_cnt`=0, skid empty, `in_ready`=1.
- While `rst_n`=0, `in_valid` is ignored.
- Reset asserted mid-operation discards both stored entries immediately; no partial state survives.
- Latency: an operation accepted at edge N, with the output register empty, has `out_valid`=1 after edge N.
- Throughput: 1 operation/cycle while `out_ready`=1.
- Back-pressure: after `out_ready` falls, at most one more operation is accepted, into the skid, before `in_ready`=0.
- The first edge after deassertion can accept an operation.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 -> `out_valid`=0, all outputs 0, `in_ready`=1, `illegal_cnt`=0.
- Decode sweep, `out_ready`=1:
  - (010, 0x22, tag 7) -> next cycle `ALU_control`=6, `out_tag`=7, `out_illegal`=0.
  - (010, 0x2E) -> 7/110.
  - (011, x) -> 7/000.
  - (101, x) -> 0.
- Illegal: (010, 0x3F), then (111, x) -> each output is 2/000 with `out_illegal`=1; `illegal_cnt`=2.
- Stall: stream tags 1,2,3 with `out_ready`=0 from cycle 1:
  - tag 1 held on the output, tag 2 in the skid, `in_ready`=0, tag 3 not accepted.
  - Raise `out_ready` -> tags 1,2,3 emerge in order with no gaps after `in_ready` recovers.
- Saturation: 300 accepted illegal operations -> `illegal_cnt`=255; it stays at 255.
- Mid-flight reset: output and skid full, assert `rst_n`=0 -> `out_valid`=0 immediately, `in_ready`=1; after release the next accepted operation is output first.
